// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and helpers.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses.
package lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  // Byte offset actually used for lane selection; misaligned low bits collapse to 0.
  function automatic logic [1:0] eff_offset(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (func3)
      F3_B, F3_BU: off = addr_lo;
      F3_H, F3_HU: off = {addr_lo[1], 1'b0};
      default:     off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic req_legal(input logic we, input logic [2:0] func3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    case (func3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    case (func3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    if (MISALIGN_TRAP && misaligned) legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response and memory-side bus of the load/store unit.
// slave = the LSU's view; master = the surrounding pipeline and memory.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic              busy;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
    output resp_ready, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / data replication and
// load data extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
    input  logic [2:0]      st_func3,
    input  logic [1:0]      st_addr_lo,
    input  logic [31:0]     st_wdata,
    output logic [BE_W-1:0] st_be,
    output logic [31:0]     st_wdata_rep,
    input  logic [2:0]      ld_func3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [31:0]     ld_rdata,
    output logic [31:0]     ld_data
);

  logic [1:0]  st_off;
  logic [1:0]  ld_off;
  logic [31:0] ld_shifted;

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    st_off       = eff_offset(st_func3, st_addr_lo);
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_func3[1:0])
      2'b00: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be        = 4'b0011 << st_off;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_off     = eff_offset(ld_func3, ld_addr_lo);
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request, runs a single memory
// transaction and holds the completion until writeback takes it.
module lsu_ctrl
  import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);

  state_t          state;
  state_t          next_state;
  logic            accept;
  logic            legal;
  logic [2:0]      func3_q;
  logic [1:0]      addr_lo_q;
  logic [BE_W-1:0] be_d;
  logic [31:0]     wdata_d;
  logic [31:0]     ld_data;

  assign accept = bus.req_valid && bus.req_ready;
  assign legal  = req_legal(bus.req_we, bus.req_func3, bus.req_addr[1:0]);

  lsu_align u_align (
    .st_func3     (bus.req_func3),
    .st_addr_lo   (bus.req_addr[1:0]),
    .st_wdata     (bus.req_wdata),
    .st_be        (be_d),
    .st_wdata_rep (wdata_d),
    .ld_func3     (func3_q),
    .ld_addr_lo   (addr_lo_q),
    .ld_rdata     (bus.mem_rdata),
    .ld_data      (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.mem_req    = (state == S_REQ);
    bus.resp_valid = (state == S_RESP);
    bus.busy       = (state != S_IDLE);
    case (state)
      S_IDLE: if (accept)         next_state = legal ? S_REQ : S_RESP;
      S_REQ:  if (bus.mem_gnt)    next_state = bus.mem_we ? S_RESP : S_WAIT;
      S_WAIT: if (bus.mem_rvalid) next_state = S_RESP;
      S_RESP: if (bus.resp_ready) next_state = S_IDLE;
      default:                    next_state = S_IDLE;
    endcase
  end

  // Memory-side fields are captured only for legal requests, so a rejected
  // access never disturbs the bus and mem_* stay stable through REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_rdata <= '0;
      bus.resp_rd    <= '0;
      bus.resp_err   <= 1'b0;
      func3_q        <= '0;
      addr_lo_q      <= '0;
    end else begin
      bus.req_ready <= (next_state == S_IDLE);
      if (accept) begin
        func3_q        <= bus.req_func3;
        addr_lo_q      <= bus.req_addr[1:0];
        bus.resp_rd    <= bus.req_rd;
        bus.resp_err   <= !legal;
        bus.resp_rdata <= '0;
        if (legal) begin
          bus.mem_we    <= bus.req_we;
          bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          bus.mem_be    <= be_d;
          bus.mem_wdata <= wdata_d;
        end
      end
      if (state == S_WAIT && bus.mem_rvalid) bus.resp_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed corner cases plus randomized
// transactions compared against an arithmetic model of the access rules.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  string cur_name = "init";

  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_name, tag, act, exp);
    end
  endtask

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && lo[0]) return 1'b1;
    if (f3[1:0] == 2'b10 && lo != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic drive_idle_inputs();
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.mem_rdata  = $urandom;
  endtask

  task automatic run_txn(input string name, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_dly,
                         input int rv_dly, input int rr_dly);
    bit          exp_err;
    int          size;
    int          off;
    int          exp_lat;
    int          req_cycles = 0;
    int          wait_cnt = 0;
    int          rr_cnt = 0;
    bit          granted = 1'b0;
    bit          got_rv = 1'b0;
    bit          seen_resp = 1'b0;
    bit          done = 1'b0;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, exp_addr, mask, v;
    logic [4:0]  rd;

    cur_name = name;
    exp_err  = model_err(we, f3, addr[1:0]);
    size     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off      = (size == 1) ? int'(addr[1:0]) : (size == 2) ? int'(addr[1]) * 2 : 0;
    exp_be   = 4'(((1 << size) - 1) << off);
    exp_wd   = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    exp_addr = addr & 32'hFFFF_FFFC;
    mask     = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    v        = (rdata >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    exp_rd   = (exp_err || we) ? 32'h0 : v;
    exp_lat  = exp_err ? 1 : we ? 2 + gnt_dly : 3 + gnt_dly + rv_dly;
    rd       = 5'($urandom);

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;

    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      drive_idle_inputs();
      bus.req_addr = $urandom;
      if (bus.mem_req) begin
        req_cycles++;
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_be", 32'(bus.mem_be), 32'(exp_be));
        check("mem_we", 32'(bus.mem_we), 32'(we));
        if (we) check("mem_wdata", bus.mem_wdata, exp_wd);
        if (req_cycles - 1 == gnt_dly) begin
          bus.mem_gnt = 1'b1;
          granted     = 1'b1;
        end else begin
          bus.mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (granted && !we && !got_rv) begin
        bus.mem_gnt = 1'($urandom_range(0, 1));
        if (wait_cnt == rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
          got_rv         = 1'b1;
        end
        wait_cnt++;
      end
      if (bus.resp_valid) begin
        if (!seen_resp) check("latency", 32'(cyc), 32'(exp_lat));
        seen_resp = 1'b1;
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check("resp_rd", 32'(bus.resp_rd), 32'(rd));
        check("req_ready_resp", 32'(bus.req_ready), 32'd0);
        if (rr_cnt == rr_dly) begin
          bus.resp_ready = 1'b1;
          done           = 1'b1;
        end
        rr_cnt++;
      end else begin
        check("busy", 32'(bus.busy), 32'd1);
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("mem_req_cycles", 32'(req_cycles), exp_err ? 32'd0 : 32'(gnt_dly + 1));

    @(negedge clk);
    drive_idle_inputs();
    check("resp_valid_done", 32'(bus.resp_valid), 32'd0);
    check("req_ready_done", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
  endtask

  task automatic reset_in_wait();
    cur_name = "rst_wait";
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b010;
    bus.req_addr  = 32'h0000_0040;
    bus.req_rd    = 5'd7;
    @(negedge clk);
    drive_idle_inputs();
    check("mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    drive_idle_inputs();
    check("in_wait", 32'(bus.mem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_resp", 32'(bus.resp_valid), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);
      check("no_mem_req", 32'(bus.mem_req), 32'd0);
    end
    drive_idle_inputs();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    drive_idle_inputs();
    repeat (3) @(negedge clk);
    cur_name = "reset";
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    run_txn("lb_zero_wait", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF12, 0, 0, 0);
    run_txn("sh_gnt_dly", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0, 0);
    run_txn("lhu_bp", 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_8001, 0, 0, 5);
    run_txn("lw_misalign", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1122_3344, 0, 0, 0);
    run_txn("bad_f3_store", 1'b1, 3'b011, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    run_txn("sbu_reject", 1'b1, 3'b100, 32'h0000_0021, 32'h5555_AAAA, 32'h0, 0, 0, 0);
    reset_in_wait();

    for (int i = 0; i < 60; i++) begin
      run_txn("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, width of the request address and the memory address.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  execute stage presents a load or store.
REQ-005 req_ready  out  1  block accepts the request; a transfer occurs when req_valid and req_ready are both high.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_func3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  ADDR_W  byte address (rs1+imm).
REQ-009 req_wdata  in  32  store data (rs2).
REQ-010 req_rd  in  5  load destination register.
REQ-011 resp_valid  out  1  completion is valid.
REQ-012 resp_ready  in  1  writeback stage accepts the completion.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and for errors.
REQ-014 resp_rd  out  5  captured req_rd.
REQ-015 resp_err  out  1  access was rejected.
REQ-016 busy  out  1  state is not IDLE.
REQ-017 mem_req  out  1  memory request.
REQ-018 mem_gnt  in  1  memory accepted the request.
REQ-019 mem_we  out  1  memory write.
REQ-020 mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are 0.
REQ-021 mem_be  out  4  byte enables.
REQ-022 mem_wdata  out  32  lane-replicated store data.
REQ-023 mem_rvalid  in  1  read data valid; arrives no earlier than the cycle after mem_gnt.
REQ-024 mem_rdata  in  32  read word.

Function
REQ-025 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-026 State transitions SHALL be:
- IDLE to REQ on an accepted legal request.
- IDLE to RESP on an accepted rejected request.
- REQ to RESP on mem_gnt for a store.
- REQ to WAIT on mem_gnt for a load.
- WAIT to RESP on mem_rvalid.
- RESP to IDLE on resp_ready.
REQ-027 req_ready SHALL be high only in IDLE; all request fields SHALL be registered on acceptance.
REQ-028 In REQ, mem_req SHALL be high, and mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable until mem_gnt; mem_req SHALL be low in every other state.
REQ-029 mem_be SHALL be:
- B: 0001 shifted left by addr[1:0].
- H: 0011 shifted left by {addr[1],0}.
- W: 1111.
REQ-030 mem_wdata SHALL replicate the byte 4x for B, replicate the halfword 2x for H, and pass the word through for W.
REQ-031 Load data SHALL be shifted right by 8*addr[1:0], sign-extended for B/H, zero-extended for BU/HU, and registered into resp_rdata on mem_rvalid.
REQ-032 In RESP, resp_valid SHALL be held with stable outputs until resp_ready; a new request is accepted at the earliest in the cycle after the RESP to IDLE transition.
REQ-033 Minimum load latency (accept at cycle T, mem_gnt at T+1, mem_rvalid at T+2): resp_valid SHALL rise at T+3.
REQ-034 Minimum store latency: resp_valid SHALL rise at T+2.
REQ-035 func3 values 011, 110 and 111, and 100/101 with req_we=1, SHALL be rejected: no memory access, resp_err=1.
REQ-036 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.

Reset
REQ-037 While rst is high at a clock edge, the block SHALL set:
- state = IDLE.
- req_ready, mem_req, mem_we and resp_valid = 0.
- resp_err, busy and mem_be = 0.
- mem_addr, mem_wdata, resp_rdata and resp_rd = 0.
REQ-038 req_ready SHALL be 1 from the first edge after rst falls.
REQ-039 Reset mid-transaction SHALL abandon the transaction; mem_req SHALL be 0 after that edge, and no response SHALL be produced.

Configuration
REQ-040 With LSU_MISALIGN_TRAP_EN defined, an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL be rejected: no memory access, resp_err=1.
REQ-041 Without LSU_MISALIGN_TRAP_EN, a misaligned access SHALL proceed with the offending low address bits treated as 0, and resp_err=0.

Structure
REQ-042 Package lsu_pkg SHALL hold the func3 width constants, the FSM state enum and the byte-enable width.
REQ-043 The combinational sub-module lsu_align SHALL compute mem_be, mem_wdata and load extraction/extension; lsu_ctrl SHALL hold the FSM and registers.

Verification
REQ-044 The bench SHALL cover these directed scenarios:
- LB, addr=0x103, mem_rdata=0x80FF_FF12, gnt and rvalid zero-wait -> mem_be=1000, mem_addr=0x100, resp_rdata=0xFFFF_FF80 at T+3.
- SH, addr=0x202, wdata=0x1234_ABCD, gnt delayed 3 cycles -> mem_req and mem_be=1100 held 4 cycles, mem_wdata=0xABCD_ABCD, resp_err=0.
- LHU, addr=0x00, mem_rdata=0x0000_8001, resp_ready low for 5 cycles -> resp_valid and resp_rdata=0x0000_8001 held; req_ready=0 throughout.
- LW, addr=0x06 -> with the macro: resp_err=1 and mem_req never asserted; without the macro: mem_addr=0x04.
- func3=011 store -> resp_err=1, resp_rdata=0, no mem_req.
- rst pulsed in WAIT -> state IDLE, mem_req=0, resp_valid never asserted; a later mem_rvalid is ignored.
